// File: rtl/mips_cpu_harvard_core_if.sv
// Harvard memory bus between the MIPS core and its instruction/data memories.
// Both memories answer combinationally within the cycle.
interface mips_cpu_harvard_core_if;
    logic [31:0] instr_address;
    logic [31:0] instr_readdata;
    logic [31:0] data_address;
    logic        data_write;
    logic        data_read;
    logic [31:0] data_writedata;
    logic [31:0] data_readdata;

    modport master (
        output instr_address, data_address, data_write, data_read, data_writedata,
        input  instr_readdata, data_readdata
    );

    modport slave (
        input  instr_address, data_address, data_write, data_read, data_writedata,
        output instr_readdata, data_readdata
    );
endinterface

// File: rtl/mips_cpu_harvard_core.sv
// Single-cycle MIPS32 subset core with one branch delay slot; it stops executing
// once the PC reaches address zero.
module mips_cpu_harvard_core (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            clk_enable,
    output logic                            active,
    output logic [31:0]                     register_v0,
    mips_cpu_harvard_core_if.master         bus
);
    logic [31:0] pc_q, pc_d, npc_q, npc_d;
    logic        active_q, active_d;
    logic [31:0] regs_q [32];

    logic [5:0]  opcode_s, funct_s;
    logic [4:0]  rs_s, rt_s, rd_s, shamt_s;
    logic [15:0] imm_s;
    logic [25:0] jidx_s;
    logic [31:0] rs_val_s, rt_val_s, sext_s, zext_s, pc_plus4_s, pc_plus8_s;
    logic [31:0] alu_s, wr_data_s, target_s;
    logic [4:0]  wr_addr_s;
    logic        wr_en_s, mem_rd_s, mem_wr_s, jump_s, we_s;

    assign opcode_s   = bus.instr_readdata[31:26];
    assign rs_s       = bus.instr_readdata[25:21];
    assign rt_s       = bus.instr_readdata[20:16];
    assign rd_s       = bus.instr_readdata[15:11];
    assign shamt_s    = bus.instr_readdata[10:6];
    assign funct_s    = bus.instr_readdata[5:0];
    assign imm_s      = bus.instr_readdata[15:0];
    assign jidx_s     = bus.instr_readdata[25:0];
    assign rs_val_s   = regs_q[rs_s];
    assign rt_val_s   = regs_q[rt_s];
    assign sext_s     = {{16{imm_s[15]}}, imm_s};
    assign zext_s     = {16'h0000, imm_s};
    assign pc_plus4_s = pc_q + 32'd4;
    assign pc_plus8_s = pc_q + 32'd8;

    // Instruction decode and execute; unsupported encodings fall through as NOPs.
    always_comb begin
        wr_en_s   = 1'b0;
        wr_addr_s = rt_s;
        alu_s     = 32'd0;
        mem_rd_s  = 1'b0;
        mem_wr_s  = 1'b0;
        jump_s    = 1'b0;
        target_s  = 32'd0;
        case (opcode_s)
            6'h00: begin
                wr_addr_s = rd_s;
                wr_en_s   = 1'b1;
                case (funct_s)
                    6'h21:   alu_s = rs_val_s + rt_val_s;
                    6'h23:   alu_s = rs_val_s - rt_val_s;
                    6'h24:   alu_s = rs_val_s & rt_val_s;
                    6'h25:   alu_s = rs_val_s | rt_val_s;
                    6'h26:   alu_s = rs_val_s ^ rt_val_s;
                    6'h2A:   alu_s = {31'd0, ($signed(rs_val_s) < $signed(rt_val_s))};
                    6'h2B:   alu_s = {31'd0, (rs_val_s < rt_val_s)};
                    6'h00:   alu_s = rt_val_s << shamt_s;
                    6'h02:   alu_s = rt_val_s >> shamt_s;
                    6'h03:   alu_s = $unsigned($signed(rt_val_s) >>> shamt_s);
                    6'h08: begin
                        wr_en_s  = 1'b0;
                        jump_s   = 1'b1;
                        target_s = rs_val_s;
                    end
                    6'h09: begin
                        jump_s   = 1'b1;
                        target_s = rs_val_s;
                        alu_s    = pc_plus8_s;
                    end
                    default: wr_en_s = 1'b0;
                endcase
            end
            6'h09: begin wr_en_s = 1'b1; alu_s = rs_val_s + sext_s; end
            6'h0C: begin wr_en_s = 1'b1; alu_s = rs_val_s & zext_s; end
            6'h0D: begin wr_en_s = 1'b1; alu_s = rs_val_s | zext_s; end
            6'h0E: begin wr_en_s = 1'b1; alu_s = rs_val_s ^ zext_s; end
            6'h0A: begin wr_en_s = 1'b1; alu_s = {31'd0, ($signed(rs_val_s) < $signed(sext_s))}; end
            6'h0B: begin wr_en_s = 1'b1; alu_s = {31'd0, (rs_val_s < sext_s)}; end
            6'h0F: begin wr_en_s = 1'b1; alu_s = {imm_s, 16'h0000}; end
            6'h23: begin wr_en_s = 1'b1; mem_rd_s = 1'b1; alu_s = rs_val_s + sext_s; end
            6'h2B: begin mem_wr_s = 1'b1; alu_s = rs_val_s + sext_s; end
            6'h04: begin
                jump_s   = (rs_val_s == rt_val_s);
                target_s = pc_plus4_s + {sext_s[29:0], 2'b00};
            end
            6'h05: begin
                jump_s   = (rs_val_s != rt_val_s);
                target_s = pc_plus4_s + {sext_s[29:0], 2'b00};
            end
            6'h02: begin
                jump_s   = 1'b1;
                target_s = {pc_plus4_s[31:28], jidx_s, 2'b00};
            end
            6'h03: begin
                jump_s    = 1'b1;
                target_s  = {pc_plus4_s[31:28], jidx_s, 2'b00};
                wr_en_s   = 1'b1;
                wr_addr_s = 5'd31;
                alu_s     = pc_plus8_s;
            end
            default: wr_en_s = 1'b0;
        endcase
    end

    // Kept apart from decode so the load path through data memory stays acyclic.
    assign wr_data_s = mem_rd_s ? bus.data_readdata : alu_s;

    // Next-state selection: the delay slot runs from npc_q while the target queues behind it.
    always_comb begin
        pc_d     = pc_q;
        npc_d    = npc_q;
        active_d = active_q;
        we_s     = 1'b0;
        if (active_q && clk_enable) begin
            pc_d     = npc_q;
            npc_d    = jump_s ? target_s : (npc_q + 32'd4);
            active_d = (npc_q != 32'd0);
            we_s     = wr_en_s && (wr_addr_s != 5'd0);
        end else begin
            pc_d     = pc_q;
            npc_d    = npc_q;
            active_d = active_q;
            we_s     = 1'b0;
        end
    end

    // Architectural state: PC pair, active flag and register file.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= 32'hBFC0_0000;
            npc_q    <= 32'hBFC0_0004;
            active_q <= 1'b1;
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 32'd0;
            end
        end else begin
            pc_q     <= pc_d;
            npc_q    <= npc_d;
            active_q <= active_d;
            if (we_s) begin
                regs_q[wr_addr_s] <= wr_data_s;
            end
        end
    end

    assign active             = active_q;
    assign register_v0        = regs_q[2];
    assign bus.instr_address  = pc_q;
    assign bus.data_address   = alu_s;
    assign bus.data_writedata = rt_val_s;
    assign bus.data_write     = mem_wr_s && active_q && clk_enable;
    assign bus.data_read      = mem_rd_s && active_q;
endmodule

// File: tb/tb_mips_cpu_harvard_core.sv
// Directed bench for mips_cpu_harvard_core: small hand-assembled programs with
// hand-computed register, PC and bus expectations.
module tb_mips_cpu_harvard_core;
    logic        clk;
    logic        reset;
    logic        clk_enable;
    logic        active;
    logic [31:0] register_v0;
    int          ntests;
    int          nfail;

    logic [31:0] imem [256];
    logic [31:0] dmem [256];

    mips_cpu_harvard_core_if bus ();

    mips_cpu_harvard_core dut (
        .clk         (clk),
        .reset       (reset),
        .clk_enable  (clk_enable),
        .active      (active),
        .register_v0 (register_v0),
        .bus         (bus.master)
    );

    always #5 clk = ~clk;

    assign bus.instr_readdata = imem[bus.instr_address[9:2]];
    assign bus.data_readdata  = dmem[bus.data_address[9:2]];

    always @(posedge clk) begin
        if (bus.data_write) dmem[bus.data_address[9:2]] <= bus.data_writedata;
    end

    function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd,
                                          input logic [4:0] sh);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [31:0] tgt);
        return {op, tgt[27:2]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic clear_imem();
        for (int k = 0; k < 256; k++) imem[k] = 32'd0;
    endtask

    initial begin
        clk = 1'b0; reset = 1'b1; clk_enable = 1'b1;
        ntests = 0; nfail = 0;

        // Test 1: ADDIU $2,$0,5; JR $0; NOP
        clear_imem();
        imem[0] = enc_i(6'h09, 5'd0, 5'd2, 16'd5);
        imem[1] = enc_r(6'h08, 5'd0, 5'd0, 5'd0, 5'd0);
        do_reset();
        check("reset_pc", bus.instr_address, 32'hBFC0_0000);
        check("reset_active", {31'd0, active}, 32'd1);
        check("reset_v0", register_v0, 32'd0);
        step(1);
        check("t1_v0", register_v0, 32'd5);
        step(1);
        check("t1_delay_pc", bus.instr_address, 32'hBFC0_0008);
        check("t1_active_slot", {31'd0, active}, 32'd1);
        step(1);
        check("t1_halt_pc", bus.instr_address, 32'd0);
        check("t1_halt_active", {31'd0, active}, 32'd0);
        step(2);
        check("t1_pc_frozen", bus.instr_address, 32'd0);
        check("t1_v0_kept", register_v0, 32'd5);

        // Test 2: LUI/ORI/JR $3 with delay-slot ADDIU, interrupted once by a reset
        clear_imem();
        imem[0] = enc_i(6'h0F, 5'd0, 5'd3, 16'h1234);
        imem[1] = enc_i(6'h0D, 5'd3, 5'd3, 16'h5678);
        imem[2] = enc_r(6'h08, 5'd3, 5'd0, 5'd0, 5'd0);
        imem[3] = enc_i(6'h09, 5'd0, 5'd2, 16'd7);
        do_reset();
        step(3);
        check("t2_pre_reset_pc", bus.instr_address, 32'hBFC0_000C);
        clk_enable = 1'b0;
        do_reset();
        check("t2_rst_pc", bus.instr_address, 32'hBFC0_0000);
        check("t2_rst_active", {31'd0, active}, 32'd1);
        clk_enable = 1'b1;
        step(1);
        check("t2_after_rst_pc", bus.instr_address, 32'hBFC0_0004);
        step(3);
        check("t2_slot_v0", register_v0, 32'd7);
        check("t2_jr_target", bus.instr_address, 32'h1234_5678);

        // Test 3: SW then LW through the data port
        clear_imem();
        imem[0] = enc_i(6'h0F, 5'd0, 5'd4, 16'hDEAD);
        imem[1] = enc_i(6'h0D, 5'd4, 5'd4, 16'hBEEF);
        imem[2] = enc_i(6'h09, 5'd0, 5'd5, 16'h1000);
        imem[3] = enc_i(6'h2B, 5'd5, 5'd4, 16'h0000);
        imem[4] = enc_i(6'h23, 5'd5, 5'd2, 16'h0000);
        do_reset();
        step(3);
        check("t3_sw_write", {31'd0, bus.data_write}, 32'd1);
        check("t3_sw_read", {31'd0, bus.data_read}, 32'd0);
        check("t3_sw_addr", bus.data_address, 32'h0000_1000);
        check("t3_sw_data", bus.data_writedata, 32'hDEAD_BEEF);
        step(1);
        check("t3_lw_read", {31'd0, bus.data_read}, 32'd1);
        check("t3_lw_write", {31'd0, bus.data_write}, 32'd0);
        check("t3_lw_addr", bus.data_address, 32'h0000_1000);
        step(1);
        check("t3_lw_v0", register_v0, 32'hDEAD_BEEF);

        // Test 4: branches, JAL/JR $31, SLT/SLTU, clock-enable hold, $0 write, SRA
        clear_imem();
        imem[0]  = enc_i(6'h09, 5'd0, 5'd6, 16'd1);
        imem[1]  = enc_i(6'h04, 5'd6, 5'd0, 16'd5);
        imem[3]  = enc_i(6'h04, 5'd6, 5'd6, 16'd2);
        imem[4]  = enc_i(6'h09, 5'd0, 5'd2, 16'h0011);
        imem[5]  = enc_i(6'h09, 5'd0, 5'd2, 16'h0022);
        imem[6]  = enc_j(6'h03, 32'hBFC0_0060);
        imem[8]  = enc_r(6'h21, 5'd31, 5'd0, 5'd2, 5'd0);
        imem[9]  = enc_r(6'h2A, 5'd7, 5'd6, 5'd2, 5'd0);
        imem[10] = enc_r(6'h2B, 5'd7, 5'd6, 5'd2, 5'd0);
        imem[11] = enc_i(6'h09, 5'd0, 5'd0, 16'd9);
        imem[12] = enc_r(6'h25, 5'd0, 5'd0, 5'd2, 5'd0);
        imem[13] = enc_r(6'h03, 5'd0, 5'd7, 5'd2, 5'd4);
        imem[14] = enc_r(6'h08, 5'd0, 5'd0, 5'd0, 5'd0);
        imem[24] = enc_i(6'h09, 5'd0, 5'd7, 16'hFFFF);
        imem[25] = enc_r(6'h08, 5'd31, 5'd0, 5'd0, 5'd0);
        do_reset();
        step(3);
        check("t4_beq_not_taken", bus.instr_address, 32'hBFC0_000C);
        step(2);
        check("t4_beq_slot_v0", register_v0, 32'h0000_0011);
        check("t4_beq_taken", bus.instr_address, 32'hBFC0_0018);
        step(2);
        check("t4_jal_target", bus.instr_address, 32'hBFC0_0060);
        step(3);
        check("t4_jr31_target", bus.instr_address, 32'hBFC0_0020);
        step(1);
        check("t4_ra_value", register_v0, 32'hBFC0_0020);
        step(1);
        check("t4_slt", register_v0, 32'd1);
        clk_enable = 1'b0;
        step(3);
        check("t4_hold_pc", bus.instr_address, 32'hBFC0_0028);
        check("t4_hold_v0", register_v0, 32'd1);
        check("t4_hold_active", {31'd0, active}, 32'd1);
        clk_enable = 1'b1;
        step(1);
        check("t4_sltu", register_v0, 32'd0);
        step(2);
        check("t4_zero_reg", register_v0, 32'd0);
        step(1);
        check("t4_sra", register_v0, 32'hFFFF_FFFF);
        step(2);
        check("t4_halt_pc", bus.instr_address, 32'd0);
        check("t4_halt_active", {31'd0, active}, 32'd0);
        check("t4_halt_dwrite", {31'd0, bus.data_write}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
